// File: rtl/uart_report_sched_if.sv
// rtl/uart_report_sched_if.sv - sample input and uart_tx handshake bundle for uart_report_sched
interface uart_report_sched_if;
    logic       i_valid;
    logic [7:0] i_hum_int;
    logic [7:0] i_hum_dec;
    logic [7:0] i_tmp_int;
    logic [7:0] i_tmp_dec;
    logic [7:0] o_tx_data;
    logic       o_tx_en;
    logic       i_tx_done;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_drop;
    logic       o_timeout;

    modport master (
        output i_valid, i_hum_int, i_hum_dec, i_tmp_int, i_tmp_dec, i_tx_done,
        input  o_tx_data, o_tx_en, o_busy, o_frame_done, o_drop, o_timeout
    );

    modport slave (
        input  i_valid, i_hum_int, i_hum_dec, i_tmp_int, i_tmp_dec, i_tx_done,
        output o_tx_data, o_tx_en, o_busy, o_frame_done, o_drop, o_timeout
    );
endinterface

// File: rtl/uart_report_sched.sv
// rtl/uart_report_sched.sv - formats DHT11 samples as ASCII reports and feeds them bytewise to uart_tx
module uart_report_sched #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_report_sched_if.slave bus
);
    localparam int FRAME_LEN = 15;
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0]       LAST_IDX = 4'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT, ST_DONE} state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] tmo_cnt;
    logic             pending;
    logic [7:0]       pend_hi, pend_hd, pend_ti, pend_td;
    logic [7:0]       cap_hi, cap_hd, cap_ti, cap_td;
    logic [7:0]       dig_h1, dig_h0, dig_hd, dig_t1, dig_t0, dig_td;
    logic [7:0]       tx_data_q;
    logic             tx_en_q, frame_done_q, drop_q, timeout_q;
    logic [3:0]       nxt_idx;
    logic [7:0]       nxt_byte;

    // Clamp to 99 and split into tens/ones with a compare chain instead of a divider.
    function automatic logic [15:0] int_ascii(input logic [7:0] v);
        logic [7:0] c, tens, ones;
        c    = (v > 8'd99) ? 8'd99 : v;
        tens = 8'd0;
        for (int k = 1; k <= 9; k++)
            if (c >= 8'(k * 10)) tens = 8'(k);
        ones = c - tens * 8'd10;
        return {8'h30 + tens, 8'h30 + ones};
    endfunction

    function automatic logic [7:0] dec_ascii(input logic [7:0] v);
        return (v > 8'd9) ? 8'h39 : 8'h30 + v;
    endfunction

    always_comb begin
        nxt_idx  = idx + 4'd1;
        nxt_byte = 8'h0A;
        case (nxt_idx)
            4'd0:    nxt_byte = 8'h48;
            4'd1:    nxt_byte = 8'h3D;
            4'd2:    nxt_byte = dig_h1;
            4'd3:    nxt_byte = dig_h0;
            4'd4:    nxt_byte = 8'h2E;
            4'd5:    nxt_byte = dig_hd;
            4'd6:    nxt_byte = 8'h20;
            4'd7:    nxt_byte = 8'h54;
            4'd8:    nxt_byte = 8'h3D;
            4'd9:    nxt_byte = dig_t1;
            4'd10:   nxt_byte = dig_t0;
            4'd11:   nxt_byte = 8'h2E;
            4'd12:   nxt_byte = dig_td;
            4'd13:   nxt_byte = 8'h0D;
            default: nxt_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= 4'd0;
            tmo_cnt      <= '0;
            pending      <= 1'b0;
            pend_hi      <= 8'd0;
            pend_hd      <= 8'd0;
            pend_ti      <= 8'd0;
            pend_td      <= 8'd0;
            cap_hi       <= 8'd0;
            cap_hd       <= 8'd0;
            cap_ti       <= 8'd0;
            cap_td       <= 8'd0;
            dig_h1       <= 8'd0;
            dig_h0       <= 8'd0;
            dig_hd       <= 8'd0;
            dig_t1       <= 8'd0;
            dig_t0       <= 8'd0;
            dig_td       <= 8'd0;
            tx_data_q    <= 8'd0;
            tx_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            tx_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= 1'b0;
            timeout_q    <= 1'b0;

            // Samples arriving mid-frame park in the one-deep buffer; newest wins.
            if (bus.i_valid && state != ST_IDLE) begin
                pend_hi <= bus.i_hum_int;
                pend_hd <= bus.i_hum_dec;
                pend_ti <= bus.i_tmp_int;
                pend_td <= bus.i_tmp_dec;
                pending <= 1'b1;
                drop_q  <= pending;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        cap_hi <= bus.i_hum_int;
                        cap_hd <= bus.i_hum_dec;
                        cap_ti <= bus.i_tmp_int;
                        cap_td <= bus.i_tmp_dec;
                        if (pending) begin
                            pending <= 1'b0;
                            drop_q  <= 1'b1;
                        end
                        state <= ST_LOAD;
                    end else if (pending) begin
                        cap_hi  <= pend_hi;
                        cap_hd  <= pend_hd;
                        cap_ti  <= pend_ti;
                        cap_td  <= pend_td;
                        pending <= 1'b0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    {dig_h1, dig_h0} <= int_ascii(cap_hi);
                    dig_hd           <= dec_ascii(cap_hd);
                    {dig_t1, dig_t0} <= int_ascii(cap_ti);
                    dig_td           <= dec_ascii(cap_td);
                    idx              <= 4'd0;
                    tx_en_q          <= 1'b1;
                    tx_data_q        <= 8'h48;
                    state            <= ST_SEND;
                end
                ST_SEND: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_tx_done) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx       <= nxt_idx;
                            tx_en_q   <= 1'b1;
                            tx_data_q <= nxt_byte;
                            state     <= ST_SEND;
                        end
                    end else if (tmo_cnt == CNT_MAX) begin
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    frame_done_q <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_en      = tx_en_q;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_drop       = drop_q;
    assign bus.o_timeout    = timeout_q;
    assign bus.o_busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_report_sched.sv
// tb/tb_uart_report_sched.sv - directed self-checking bench for uart_report_sched
module tb_uart_report_sched;
    logic clk;
    logic rst_n;
    uart_report_sched_if ifc ();

    uart_report_sched #(.TIMEOUT_CYCLES(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int model_delay = 50;
    int inj_at [2];
    logic [31:0] inj_fld [2];
    logic inj_drop [2];
    logic [14:0] spur_mask;

    localparam logic [119:0] F1 = 120'h483D34352E3020543D32332E350D0A;
    localparam logic [119:0] F2 = 120'h483D39392E3920543D30372E300D0A;
    localparam logic [119:0] F3 = 120'h483D30302E3020543D39392E390D0A;
    localparam logic [119:0] FB = 120'h483D38382E3820543D36362E360D0A;
    localparam logic [119:0] FP = 120'h483D31322E3320543D33342E360D0A;
    localparam logic [119:0] FR = 120'h483D39392E3920543D30302E300D0A;
    localparam logic [119:0] F6 = 120'h483D30392E3920543D31302E300D0A;

    always @(posedge clk) if (ifc.o_tx_en === 1'b1) en_cnt++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [31:0] f);
        ifc.i_hum_int = f[31:24];
        ifc.i_hum_dec = f[23:16];
        ifc.i_tmp_int = f[15:8];
        ifc.i_tmp_dec = f[7:0];
    endtask

    task automatic pulse_valid(input logic [31:0] f);
        set_fields(f);
        ifc.i_valid = 1'b1;
        tick();
        ifc.i_valid = 1'b0;
    endtask

    // Acts as uart_tx: answers each o_tx_en with a one-cycle done after model_delay cycles.
    task automatic run_frame(input logic [119:0] frm, input int nbytes, input int lat);
        int k;
        k = 0;
        while (ifc.o_tx_en !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("first_en_seen", ifc.o_tx_en, 1'b1);
        if (lat >= 0) chk("first_en_latency", k, lat);
        for (int i = 0; i < nbytes; i++) begin
            chk("en_at_send", ifc.o_tx_en, 1'b1);
            chk("byte", ifc.o_tx_data, frm[119-8*i -: 8]);
            if (spur_mask[i]) begin
                ifc.i_tx_done = 1'b1;
                tick();
                ifc.i_tx_done = 1'b0;
                chk("spur_no_en", ifc.o_tx_en, 1'b0);
            end
            for (int c = 0; c < model_delay; c++) begin
                if (c == 10) begin
                    for (int j = 0; j < 2; j++) begin
                        if (inj_at[j] == i) begin
                            pulse_valid(inj_fld[j]);
                            chk("drop", ifc.o_drop, inj_drop[j]);
                        end
                    end
                end
                tick();
            end
            chk("data_hold", ifc.o_tx_data, frm[119-8*i -: 8]);
            ifc.i_tx_done = 1'b1;
            tick();
            ifc.i_tx_done = 1'b0;
        end
        if (nbytes == 15) begin
            chk("done_state_fd_low", ifc.o_frame_done, 1'b0);
            chk("done_state_busy", ifc.o_busy, 1'b1);
            tick();
            chk("frame_done_pulse", ifc.o_frame_done, 1'b1);
            chk("busy_falls", ifc.o_busy, 1'b0);
        end
    endtask

    initial begin
        int k;
        int e0;
        rst_n = 1'b0;
        ifc.i_valid = 1'b0;
        ifc.i_tx_done = 1'b0;
        set_fields(32'd0);
        inj_at[0] = -1;
        inj_at[1] = -1;
        inj_fld[0] = 32'd0;
        inj_fld[1] = 32'd0;
        inj_drop[0] = 1'b0;
        inj_drop[1] = 1'b0;
        spur_mask = 15'd0;
        tick();
        tick();
        chk("rst_tx_en", ifc.o_tx_en, 1'b0);
        chk("rst_tx_data", ifc.o_tx_data, 8'h00);
        chk("rst_busy", ifc.o_busy, 1'b0);
        chk("rst_frame_done", ifc.o_frame_done, 1'b0);
        chk("rst_drop", ifc.o_drop, 1'b0);
        chk("rst_timeout", ifc.o_timeout, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic frame 45.0 / 23.5
        e0 = en_cnt;
        pulse_valid({8'd45, 8'd0, 8'd23, 8'd5});
        run_frame(F1, 15, 1);
        chk("t1_en_count", en_cnt - e0, 15);
        tick();
        chk("t1_fd_single", ifc.o_frame_done, 1'b0);
        chk("t1_idle", ifc.o_busy, 1'b0);

        // Clamping
        pulse_valid({8'd150, 8'd12, 8'd7, 8'd0});
        run_frame(F2, 15, 1);
        tick();

        // Two samples mid-frame: second overwrites, then runs back-to-back
        inj_at[0] = 3;  inj_fld[0] = {8'd10, 8'd1, 8'd20, 8'd2}; inj_drop[0] = 1'b0;
        inj_at[1] = 7;  inj_fld[1] = {8'd88, 8'd8, 8'd66, 8'd6}; inj_drop[1] = 1'b1;
        pulse_valid({8'd0, 8'd0, 8'd99, 8'd9});
        run_frame(F3, 15, 1);
        inj_at[0] = -1;
        inj_at[1] = -1;
        run_frame(FB, 15, 2);
        repeat (3) tick();
        chk("t3_no_third_frame", ifc.o_busy, 1'b0);

        // Timeout with pending sample resuming
        e0 = en_cnt;
        pulse_valid({8'd1, 8'd1, 8'd1, 8'd1});
        k = 0;
        while (ifc.o_tx_en !== 1'b1 && k < 20) begin tick(); k++; end
        chk("t4_en_seen", ifc.o_tx_en, 1'b1);
        k = 0;
        while (ifc.o_timeout !== 1'b1 && k < 1200) begin
            if (k == 100) begin
                set_fields({8'd12, 8'd3, 8'd34, 8'd6});
                ifc.i_valid = 1'b1;
            end else begin
                ifc.i_valid = 1'b0;
            end
            tick();
            k++;
        end
        ifc.i_valid = 1'b0;
        chk("t4_timeout_latency", k, 1025);
        chk("t4_busy_after_tmo", ifc.o_busy, 1'b0);
        chk("t4_single_en", en_cnt - e0, 1);
        run_frame(FP, 15, 2);
        tick();

        // Timeout, then a fresh sample in IDLE displaces the pending one
        pulse_valid({8'd5, 8'd5, 8'd5, 8'd5});
        k = 0;
        while (ifc.o_tx_en !== 1'b1 && k < 20) begin tick(); k++; end
        k = 0;
        while (ifc.o_timeout !== 1'b1 && k < 1200) begin
            if (k == 100) begin
                set_fields({8'd77, 8'd7, 8'd77, 8'd7});
                ifc.i_valid = 1'b1;
            end else begin
                ifc.i_valid = 1'b0;
            end
            tick();
            k++;
        end
        ifc.i_valid = 1'b0;
        chk("t4b_timeout_latency", k, 1025);
        pulse_valid({8'd255, 8'd255, 8'd0, 8'd0});
        chk("t4b_idle_drop", ifc.o_drop, 1'b1);
        run_frame(FR, 15, 1);
        repeat (4) tick();
        chk("t4b_pending_cleared", ifc.o_busy, 1'b0);

        // Asynchronous reset mid-frame
        pulse_valid({8'd45, 8'd0, 8'd23, 8'd5});
        run_frame(F1, 5, 1);
        chk("t5_en_before_rst", ifc.o_tx_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_tx_en", ifc.o_tx_en, 1'b0);
        chk("t5_async_data", ifc.o_tx_data, 8'h00);
        chk("t5_async_busy", ifc.o_busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_valid({8'd45, 8'd0, 8'd23, 8'd5});
        run_frame(F1, 15, 1);
        tick();

        // Spurious done in IDLE and during SEND
        e0 = en_cnt;
        ifc.i_tx_done = 1'b1;
        tick();
        tick();
        ifc.i_tx_done = 1'b0;
        chk("t6_idle_busy", ifc.o_busy, 1'b0);
        chk("t6_idle_no_en", en_cnt - e0, 0);
        spur_mask = 15'b100_0000_0000_0101;
        pulse_valid({8'd9, 8'd9, 8'd10, 8'd0});
        run_frame(F6, 15, 1);
        spur_mask = 15'd0;
        chk("t6_en_count", en_cnt - e0, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
